// File: rtl/key_command_encoder.sv
// Frame-rate keyboard front end: HID keycodes -> debounced one-hot direction and zoom strobes.
// Define KEYCMD_AUTOREPEAT_EN to enable hold-to-auto-repeat on the zoom strobes.
module key_command_encoder #(
  parameter int unsigned DEBOUNCE_FRAMES = 2,
  parameter int unsigned REPEAT_DELAY    = 30,
  parameter int unsigned REPEAT_PERIOD   = 6
) (
  input  logic       Reset,
  input  logic       frame_clk,
  input  logic       hid_valid,
  input  logic [7:0] hid_key0,
  input  logic [7:0] hid_key1,
  output logic [5:0] keycode,
  output logic       Zoom_In,
  output logic       Zoom_Out
);

  localparam logic [7:0] KeyA = 8'h04;
  localparam logic [7:0] KeyD = 8'h07;
  localparam logic [7:0] KeyW = 8'h1A;
  localparam logic [7:0] KeyS = 8'h16;
  localparam logic [7:0] KeyE = 8'h08;
  localparam logic [7:0] KeyQ = 8'h14;

  localparam logic [5:0] DirNone = 6'b000000;
  localparam logic [5:0] DirA    = 6'b100000;
  localparam logic [5:0] DirD    = 6'b010000;
  localparam logic [5:0] DirW    = 6'b001000;
  localparam logic [5:0] DirS    = 6'b000100;

  localparam logic [1:0] ZqNone = 2'd0;
  localparam logic [1:0] ZqIn   = 2'd1;
  localparam logic [1:0] ZqOut  = 2'd2;

  localparam logic [1:0] StIdle   = 2'd0;
  localparam logic [1:0] StHold   = 2'd1;
  localparam logic [1:0] StRepeat = 2'd2;

  localparam logic [3:0] DbMax    = 4'(DEBOUNCE_FRAMES);
  // The stable count excludes the first frame of a new candidate, so commit one short of max.
  localparam logic [3:0] DbCommit = 4'(DEBOUNCE_FRAMES - 1);

`ifdef KEYCMD_AUTOREPEAT_EN
  localparam logic [7:0] DelayLast  = 8'(REPEAT_DELAY - 1);
  localparam logic [7:0] PeriodLast = 8'(REPEAT_PERIOD - 1);
`endif

  if (DEBOUNCE_FRAMES < 1 || DEBOUNCE_FRAMES > 15) begin : g_bad_debounce
    $error("DEBOUNCE_FRAMES must be in 1..15");
  end
  if (REPEAT_DELAY < 1 || REPEAT_DELAY > 255) begin : g_bad_delay
    $error("REPEAT_DELAY must be in 1..255");
  end
  if (REPEAT_PERIOD < 1 || REPEAT_PERIOD > 255) begin : g_bad_period
    $error("REPEAT_PERIOD must be in 1..255");
  end

  function automatic logic [5:0] dir_decode(input logic [7:0] code);
    logic [5:0] dir;
    case (code)
      KeyA:    dir = DirA;
      KeyD:    dir = DirD;
      KeyW:    dir = DirW;
      KeyS:    dir = DirS;
      default: dir = DirNone;
    endcase
    return dir;
  endfunction

  // Sample stage
  logic [7:0] s0_q, s1_q;

  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      s0_q <= 8'h00;
      s1_q <= 8'h00;
    end else if (hid_valid) begin
      s0_q <= hid_key0;
      s1_q <= hid_key1;
    end
  end

  // Candidate decode
  logic [5:0] dir0, dir1, dir_cand;
  logic       has_e, has_q;
  logic [1:0] zoom_cand;

  always_comb begin
    dir0     = dir_decode(s0_q);
    dir1     = dir_decode(s1_q);
    dir_cand = (dir0 != DirNone) ? dir0 : dir1;

    has_e     = (s0_q == KeyE) || (s1_q == KeyE);
    has_q     = (s0_q == KeyQ) || (s1_q == KeyQ);
    zoom_cand = ZqNone;
    if (has_e && !has_q) begin
      zoom_cand = ZqIn;
    end else if (has_q && !has_e) begin
      zoom_cand = ZqOut;
    end
  end

  // Debounce
  logic [5:0] dir_prev_q, keycode_q;
  logic [3:0] dir_cnt_q, dir_cnt_d;
  logic [1:0] zoom_prev_q, zq_q;
  logic [3:0] zoom_cnt_q, zoom_cnt_d;
  logic       dir_commit, zoom_commit;

  always_comb begin
    dir_cnt_d = 4'd0;
    if (dir_cand == dir_prev_q) begin
      dir_cnt_d = (dir_cnt_q >= DbMax) ? DbMax : dir_cnt_q + 4'd1;
    end
    zoom_cnt_d = 4'd0;
    if (zoom_cand == zoom_prev_q) begin
      zoom_cnt_d = (zoom_cnt_q >= DbMax) ? DbMax : zoom_cnt_q + 4'd1;
    end
    dir_commit  = (dir_cnt_d >= DbCommit);
    zoom_commit = (zoom_cnt_d >= DbCommit);
  end

  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      dir_prev_q  <= DirNone;
      dir_cnt_q   <= 4'd0;
      keycode_q   <= DirNone;
      zoom_prev_q <= ZqNone;
      zoom_cnt_q  <= 4'd0;
      zq_q        <= ZqNone;
    end else begin
      dir_prev_q  <= dir_cand;
      dir_cnt_q   <= dir_cnt_d;
      zoom_prev_q <= zoom_cand;
      zoom_cnt_q  <= zoom_cnt_d;
      if (dir_commit) begin
        keycode_q <= dir_cand;
      end
      if (zoom_commit) begin
        zq_q <= zoom_cand;
      end
    end
  end

  // Zoom pulse FSM
  logic [1:0] state_q, state_d;
  logic [1:0] zdir_q, zdir_d;
  logic [7:0] rcnt_q, rcnt_d;
  logic       zin_q, zin_d, zout_q, zout_d;

  always_comb begin
    state_d = state_q;
    zdir_d  = zdir_q;
    rcnt_d  = rcnt_q;
    zin_d   = 1'b0;
    zout_d  = 1'b0;
    case (state_q)
      StIdle: begin
        if (zq_q != ZqNone) begin
          zin_d   = (zq_q == ZqIn);
          zout_d  = (zq_q == ZqOut);
          rcnt_d  = 8'd0;
          zdir_d  = zq_q;
          state_d = StHold;
        end
      end
      StHold, StRepeat: begin
        if (zq_q == ZqNone) begin
          rcnt_d  = 8'd0;
          state_d = StIdle;
        end else if (zq_q != zdir_q) begin
          zin_d   = (zq_q == ZqIn);
          zout_d  = (zq_q == ZqOut);
          rcnt_d  = 8'd0;
          zdir_d  = zq_q;
          state_d = StHold;
        end else begin
`ifdef KEYCMD_AUTOREPEAT_EN
          if (rcnt_q == ((state_q == StHold) ? DelayLast : PeriodLast)) begin
            zin_d   = (zdir_q == ZqIn);
            zout_d  = (zdir_q == ZqOut);
            rcnt_d  = 8'd0;
            state_d = StRepeat;
          end else begin
            rcnt_d = rcnt_q + 8'd1;
          end
`else
          // Single-shot: park in HOLD with the repeat counter frozen.
          rcnt_d = rcnt_q;
`endif
        end
      end
      default: begin
        rcnt_d  = 8'd0;
        zdir_d  = ZqNone;
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      state_q <= StIdle;
      zdir_q  <= ZqNone;
      rcnt_q  <= 8'd0;
      zin_q   <= 1'b0;
      zout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      zdir_q  <= zdir_d;
      rcnt_q  <= rcnt_d;
      zin_q   <= zin_d;
      zout_q  <= zout_d;
    end
  end

  assign keycode  = keycode_q;
  assign Zoom_In  = zin_q;
  assign Zoom_Out = zout_q;

endmodule
